// File: rtl/mac_term_feeder_if.sv
// Sample-in / term-out bundle of the MAC term feeder: coefficient writes,
// sample handshake, FIFO stall inputs and the term stream to the MAC FIFOs.
interface mac_term_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4
);
    logic                  coeff_we_i;
    logic [ADDR_LINES-1:0] coeff_addr_i;
    logic [DATA_WIDTH-1:0] coeff_data_i;
    logic                  sample_valid_i;
    logic                  sample_ready_o;
    logic [DATA_WIDTH-1:0] sample_i;
    logic [ADDR_LINES-1:0] order_i;
    logic                  full_mul_i;
    logic                  full_adder_i;
    logic [DATA_WIDTH-1:0] signal_o;
    logic [DATA_WIDTH-1:0] coeff_o;
    logic                  term_valid_o;
    logic                  term_last_o;
    logic                  busy_o;
    logic                  sat_o;

    modport master (
        output coeff_we_i, coeff_addr_i, coeff_data_i,
        output sample_valid_i, sample_i, order_i, full_mul_i, full_adder_i,
        input  sample_ready_o, signal_o, coeff_o, term_valid_o, term_last_o,
        input  busy_o, sat_o
    );

    modport slave (
        input  coeff_we_i, coeff_addr_i, coeff_data_i,
        input  sample_valid_i, sample_i, order_i, full_mul_i, full_adder_i,
        output sample_ready_o, signal_o, coeff_o, term_valid_o, term_last_o,
        output busy_o, sat_o
    );
endinterface

// File: rtl/mac_term_feeder.sv
// Expands one sample x into the term stream (x^k, c_k), k = 0..order, one term
// per unstalled cycle, with powers built iteratively in saturating fixed point.
module mac_term_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4,
    parameter int FRAC_BITS  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mac_term_feeder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_LINES;
    localparam int PW    = 2 * DATA_WIDTH;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                       state_q;
    logic        [ADDR_LINES-1:0] k_q;
    logic        [ADDR_LINES-1:0] order_q;
    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [DATA_WIDTH-1:0] power_q;
    logic                         sat_q;
    logic        [DATA_WIDTH-1:0] tbl_q [DEPTH];

    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         shifted;
    logic        [DATA_WIDTH:0]   hi;
    logic                         ovf;
    logic signed [DATA_WIDTH-1:0] power_d;
    logic                         stall;
    logic                         xfer;
    logic                         at_last;

    assign prod    = PW'(power_q) * PW'(x_q);
    assign shifted = prod >>> FRAC_BITS;
    // The result fits iff all bits from the target sign bit upward agree.
    assign hi      = shifted[PW-1:DATA_WIDTH-1];
    assign ovf     = !((&hi) || !(|hi));

    always_comb begin
        power_d = shifted[DATA_WIDTH-1:0];
        if (ovf)
            power_d = shifted[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    assign stall   = bus.full_mul_i | bus.full_adder_i;
    assign xfer    = (state_q == EMIT) && !stall;
    assign at_last = (k_q == order_q);

    assign bus.sample_ready_o = (state_q == IDLE);
    assign bus.busy_o         = (state_q == EMIT);
    assign bus.term_valid_o   = xfer;
    assign bus.term_last_o    = xfer && at_last;
    assign bus.signal_o       = power_q;
    assign bus.coeff_o        = tbl_q[k_q];
    assign bus.sat_o          = sat_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            order_q <= '0;
            x_q     <= '0;
            power_q <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            // Reads are asynchronous, so a same-cycle write is seen next cycle.
            if (bus.coeff_we_i) tbl_q[bus.coeff_addr_i] <= bus.coeff_data_i;
            case (state_q)
                IDLE: begin
                    if (bus.sample_valid_i) begin
                        x_q     <= bus.sample_i;
                        order_q <= bus.order_i;
                        power_q <= DATA_WIDTH'(1) << FRAC_BITS;
                        k_q     <= '0;
                        sat_q   <= 1'b0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (at_last) begin
                            state_q <= IDLE;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            power_q <= power_d;
                            if (ovf) sat_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_term_feeder.sv
// Directed bench for mac_term_feeder: hand-computed term streams, stalls,
// saturation, mid-emit reset and same-cycle coefficient writes.
module tb_mac_term_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   xfers = 0;

    mac_term_feeder_if #(.DATA_WIDTH(32), .ADDR_LINES(4)) bus ();

    mac_term_feeder #(.DATA_WIDTH(32), .ADDR_LINES(4), .FRAC_BITS(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.term_valid_o === 1'b1) xfers++;

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.coeff_we_i   = 1'b1;
        bus.coeff_addr_i = a;
        bus.coeff_data_i = d;
        tick();
        bus.coeff_we_i   = 1'b0;
    endtask

    task automatic accept(input string tag, input logic [31:0] x, input logic [3:0] ord);
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = x;
        bus.order_i        = ord;
        #1;
        chk({tag, ".ready"}, 32'(bus.sample_ready_o), 32'd1);
        tick();
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic term(input string tag, input logic [31:0] s, input logic [31:0] c,
                        input logic l);
        #1;
        chk({tag, ".valid"}, 32'(bus.term_valid_o), 32'd1);
        chk({tag, ".signal"}, bus.signal_o, s);
        chk({tag, ".coeff"}, bus.coeff_o, c);
        chk({tag, ".last"}, 32'(bus.term_last_o), 32'(l));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'd1);
        chk({tag, ".ready"}, 32'(bus.sample_ready_o), 32'd0);
        tick();
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, ".ready"}, 32'(bus.sample_ready_o), 32'd1);
        chk({tag, ".valid"}, 32'(bus.term_valid_o), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int x0;
        bus.coeff_we_i = 1'b0; bus.coeff_addr_i = '0; bus.coeff_data_i = '0;
        bus.sample_valid_i = 1'b0; bus.sample_i = '0; bus.order_i = '0;
        bus.full_mul_i = 1'b0; bus.full_adder_i = 1'b0;

        // Reset state
        #3;
        chk("rst.ready", 32'(bus.sample_ready_o), 32'd1);
        chk("rst.valid", 32'(bus.term_valid_o), 32'd0);
        chk("rst.last", 32'(bus.term_last_o), 32'd0);
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        chk("rst.sat", 32'(bus.sat_o), 32'd0);
        chk("rst.signal", bus.signal_o, 32'h0);
        chk("rst.coeff", bus.coeff_o, 32'h0);
        #9 rst = 1'b0;
        tick();

        // Basic order-2 expansion, x = 2.0
        wr(4'd0, 32'h0001_0000);
        wr(4'd1, 32'h0002_0000);
        wr(4'd2, 32'h0003_0000);
        accept("t1.acc", 32'h0002_0000, 4'd2);
        term("t1.k0", 32'h0001_0000, 32'h0001_0000, 1'b0);
        term("t1.k1", 32'h0002_0000, 32'h0002_0000, 1'b0);
        term("t1.k2", 32'h0004_0000, 32'h0003_0000, 1'b1);
        idle_chk("t1.end");

        // x = -1.0, order 3: alternating sign, no saturation
        accept("t2.acc", 32'hFFFF_0000, 4'd3);
        term("t2.k0", 32'h0001_0000, 32'h0001_0000, 1'b0);
        term("t2.k1", 32'hFFFF_0000, 32'h0002_0000, 1'b0);
        term("t2.k2", 32'h0001_0000, 32'h0003_0000, 1'b0);
        #1 chk("t2.sat_mid", 32'(bus.sat_o), 32'd0);
        term("t2.k3", 32'hFFFF_0000, 32'h0000_0000, 1'b1);
        chk("t2.sat", 32'(bus.sat_o), 32'd0);

        // Near-max x: second power update clamps
        accept("t3.acc", 32'h7FFF_0000, 4'd2);
        term("t3.k0", 32'h0001_0000, 32'h0001_0000, 1'b0);
        #1 chk("t3.sat_k1", 32'(bus.sat_o), 32'd0);
        term("t3.k1", 32'h7FFF_0000, 32'h0002_0000, 1'b0);
        #1 chk("t3.sat_k2", 32'(bus.sat_o), 32'd1);
        term("t3.k2", 32'h7FFF_FFFF, 32'h0003_0000, 1'b1);
        chk("t3.sat_sticky", 32'(bus.sat_o), 32'd1);

        // Stall for 4 cycles after the second term, then on the last term
        x0 = xfers;
        accept("t4.acc", 32'h0002_0000, 4'd3);
        #1 chk("t4.sat_clr", 32'(bus.sat_o), 32'd0);
        term("t4.k0", 32'h0001_0000, 32'h0001_0000, 1'b0);
        term("t4.k1", 32'h0002_0000, 32'h0002_0000, 1'b0);
        bus.full_adder_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4.stall.valid", 32'(bus.term_valid_o), 32'd0);
            chk("t4.stall.signal", bus.signal_o, 32'h0004_0000);
            chk("t4.stall.coeff", bus.coeff_o, 32'h0003_0000);
            tick();
        end
        bus.full_adder_i = 1'b0;
        term("t4.k2", 32'h0004_0000, 32'h0003_0000, 1'b0);
        bus.full_mul_i = 1'b1;
        #1;
        chk("t4.lstall.valid", 32'(bus.term_valid_o), 32'd0);
        chk("t4.lstall.last", 32'(bus.term_last_o), 32'd0);
        chk("t4.lstall.signal", bus.signal_o, 32'h0008_0000);
        tick();
        bus.full_mul_i = 1'b0;
        term("t4.k3", 32'h0008_0000, 32'h0000_0000, 1'b1);
        idle_chk("t4.end");
        chk("t4.xfers", 32'(xfers - x0), 32'd4);

        // Async reset mid-emit after the first of five terms
        accept("t5.acc", 32'h0002_0000, 4'd4);
        term("t5.k0", 32'h0001_0000, 32'h0001_0000, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5.rst.valid", 32'(bus.term_valid_o), 32'd0);
        chk("t5.rst.busy", 32'(bus.busy_o), 32'd0);
        chk("t5.rst.ready", 32'(bus.sample_ready_o), 32'd1);
        chk("t5.rst.signal", bus.signal_o, 32'h0);
        chk("t5.rst.coeff", bus.coeff_o, 32'h0);
        #1 rst = 1'b0;
        x0 = xfers;
        tick();
        tick();
        chk("t5.noxfer", 32'(xfers - x0), 32'd0);
        wr(4'd0, 32'h0001_1111);
        accept("t5.acc2", 32'h0002_0000, 4'd1);
        term("t5.r0", 32'h0001_0000, 32'h0001_1111, 1'b0);
        term("t5.r1", 32'h0002_0000, 32'h0000_0000, 1'b1);

        // order 0 with a same-cycle write to c0
        accept("t6.acc", 32'h0003_0000, 4'd0);
        bus.coeff_we_i   = 1'b1;
        bus.coeff_addr_i = 4'd0;
        bus.coeff_data_i = 32'h9999_0000;
        term("t6.k0", 32'h0001_0000, 32'h0001_1111, 1'b1);
        bus.coeff_we_i = 1'b0;
        idle_chk("t6.end");
        accept("t6.acc2", 32'h0003_0000, 4'd0);
        term("t6.new", 32'h0001_0000, 32'h9999_0000, 1'b1);
        idle_chk("t6.end2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
